mr_idecode: RTL and testbench

MR_IDECODE -- requirements
Module: mr_idecode

---
 rtl/mr_idecode.sv | 197 +++++++++++++++++++
 tb/tb_mr_idecode.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr_idecode.sv
// RV32I decode stage with a main+skid buffer; decoded bundle appears one cycle after accept.
// id_ready is registered (low only while the skid holds an entry); a redirect flushes both entries.
module mr_idecode #(
    parameter int XLEN    = 32,
    parameter int IMAXLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IMAXLEN-1:0] inst,
    input  logic [XLEN-1:0]    inst_pc,
    input  logic               inst_valid,
    output logic               id_ready,
    input  logic [XLEN-1:0]    wb_pc,
    input  logic               wb_pc_valid,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    ex_pc,
    output logic [3:0]         ex_op,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [2:0]         ex_funct3,
    output logic               ex_alt,
    output logic [XLEN-1:0]    ex_imm,
    output logic               ex_illegal
);

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_OPIMM   = 4'd7,
        OP_OP      = 4'd8,
        OP_FENCE   = 4'd9,
        OP_SYSTEM  = 4'd10,
        OP_ILLEGAL = 4'd15
    } op_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        op_e             op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            alt;
        logic [XLEN-1:0] imm;
    } bundle_t;

    logic [31:0] iw;
    op_e         dec_op;
    logic [31:0] imm32;
    bundle_t     dec;

    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_vld_q, main_vld_d;
    logic    skid_vld_q, skid_vld_d;
    logic    rdy_q, rdy_d;
    logic    acc, main_open;

    // The redirect target does not affect the flush decision; only the strobe does.
    logic unused_bits;
    assign unused_bits = ^{wb_pc, inst};

    assign iw = inst[31:0];

    always_comb begin
        dec_op = OP_ILLEGAL;
        if (iw[1:0] == 2'b11) begin
            case (iw[6:2])
                5'b01101: dec_op = OP_LUI;
                5'b00101: dec_op = OP_AUIPC;
                5'b11011: dec_op = OP_JAL;
                5'b11001: dec_op = OP_JALR;
                5'b11000: dec_op = OP_BRANCH;
                5'b00000: dec_op = OP_LOAD;
                5'b01000: dec_op = OP_STORE;
                5'b00100: dec_op = OP_OPIMM;
                5'b01100: dec_op = OP_OP;
                5'b00011: dec_op = OP_FENCE;
                5'b11100: dec_op = OP_SYSTEM;
                default:  dec_op = OP_ILLEGAL;
            endcase
        end
    end

    // Start from the common R/I field layout, then zero or override per class.
    always_comb begin
        dec    = '0;
        imm32  = '0;
        dec.pc = inst_pc;
        dec.op = dec_op;
        if (dec_op != OP_ILLEGAL) begin
            dec.rs1    = iw[19:15];
            dec.rd     = iw[11:7];
            dec.funct3 = iw[14:12];
        end
        case (dec_op)
            OP_LUI, OP_AUIPC: begin
                dec.rs1 = '0;
                imm32   = {iw[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.rs1 = '0;
                imm32   = {{12{iw[31]}}, iw[19:12], iw[20], iw[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_FENCE, OP_SYSTEM: begin
                imm32 = {{20{iw[31]}}, iw[31:20]};
            end
            OP_OPIMM: begin
                imm32   = {{20{iw[31]}}, iw[31:20]};
                dec.alt = (iw[14:12] == 3'b101) & iw[30];
            end
            OP_BRANCH: begin
                dec.rs2 = iw[24:20];
                dec.rd  = '0;
                imm32   = {{20{iw[31]}}, iw[7], iw[30:25], iw[11:8], 1'b0};
            end
            OP_STORE: begin
                dec.rs2 = iw[24:20];
                dec.rd  = '0;
                imm32   = {{20{iw[31]}}, iw[31:25], iw[11:7]};
            end
            OP_OP: begin
                dec.rs2 = iw[24:20];
                dec.alt = iw[30];
            end
            default: ;
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    assign acc       = inst_valid & rdy_q;
    assign main_open = ~main_vld_q | ex_ready;

    // Skid only fills while main is held; it always drains into main first.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (main_open) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = acc;
                if (acc) begin
                    main_d = dec;
                end
            end
        end else if (acc) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
        if (wb_pc_valid) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end
        rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign id_ready   = rdy_q;
    assign ex_valid   = main_vld_q;
    assign ex_pc      = main_q.pc;
    assign ex_op      = main_q.op;
    assign ex_rs1     = main_q.rs1;
    assign ex_rs2     = main_q.rs2;
    assign ex_rd      = main_q.rd;
    assign ex_funct3  = main_q.funct3;
    assign ex_alt     = main_q.alt;
    assign ex_imm     = main_q.imm;
    assign ex_illegal = (main_q.op == OP_ILLEGAL);

endmodule

// File: tb/tb_mr_idecode.sv
// Directed bench for mr_idecode: decode vectors, skid backpressure, flush and async reset.
module tb_mr_idecode;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        id_ready;
    logic [31:0] wb_pc;
    logic        wb_pc_valid;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_alt;
    logic [31:0] ex_imm;
    logic        ex_illegal;

    int checks   = 0;
    int failures = 0;

    mr_idecode #(.XLEN(32), .IMAXLEN(32)) dut (
        .clk(clk), .rst(rst),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .id_ready(id_ready),
        .wb_pc(wb_pc), .wb_pc_valid(wb_pc_valid),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op(ex_op),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_alt(ex_alt), .ex_imm(ex_imm), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] pc);
        inst       = i;
        inst_pc    = pc;
        inst_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; inst = '0; inst_pc = '0; inst_valid = 1'b0;
        wb_pc = '0; wb_pc_valid = 1'b0; ex_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({ex_valid, id_ready} !== 2'b00) begin
            failures++; $display("FAIL reset_vld_rdy got=%b exp=00", {ex_valid, id_ready});
        end
        checks++;
        if ({ex_pc, ex_imm, ex_op, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_alt} !== '0) begin
            failures++; $display("FAIL reset_data got pc=%h imm=%h op=%0d exp all zero", ex_pc, ex_imm, ex_op);
        end
        tick;
        rst = 1'b1;
        tick;
        checks++;
        if ({ex_valid, id_ready} !== 2'b01) begin
            failures++; $display("FAIL reset_release got=%b exp=01", {ex_valid, id_ready});
        end
        tick;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++; $display("FAIL reset_no_bundle got=%b exp=0", ex_valid);
        end
    endtask

    task automatic test_decode;
        ex_ready = 1'b1;
        offer(32'h00500093, 32'h100);
        tick;
        checks++;
        if ({ex_valid, ex_pc, ex_op, ex_rd, ex_rs1, ex_rs2, ex_alt} !== {1'b1, 32'h100, 4'd7, 5'd1, 5'd0, 5'd0, 1'b0}) begin
            failures++; $display("FAIL addi_fields got v=%b pc=%h op=%0d rd=%0d rs1=%0d rs2=%0d alt=%b exp v=1 pc=100 op=7 rd=1 rs1=0 rs2=0 alt=0",
                                 ex_valid, ex_pc, ex_op, ex_rd, ex_rs1, ex_rs2, ex_alt);
        end
        checks++;
        if (ex_imm !== 32'h00000005) begin
            failures++; $display("FAIL addi_imm got=%h exp=00000005", ex_imm);
        end
        offer(32'hFE000EE3, 32'h104);
        tick;
        checks++;
        if ({ex_pc, ex_op, ex_rd, ex_rs1, ex_rs2, ex_imm} !== {32'h104, 4'd4, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC}) begin
            failures++; $display("FAIL beq got pc=%h op=%0d rd=%0d imm=%h exp pc=104 op=4 rd=0 imm=fffffffc", ex_pc, ex_op, ex_rd, ex_imm);
        end
        offer(32'h123452B7, 32'h108);
        tick;
        checks++;
        if ({ex_op, ex_rd, ex_rs1, ex_rs2, ex_imm} !== {4'd0, 5'd5, 5'd0, 5'd0, 32'h12345000}) begin
            failures++; $display("FAIL lui got op=%0d rd=%0d rs1=%0d imm=%h exp op=0 rd=5 rs1=0 imm=12345000", ex_op, ex_rd, ex_rs1, ex_imm);
        end
        offer(32'h402081B3, 32'h10C);
        tick;
        checks++;
        if ({ex_op, ex_rd, ex_rs1, ex_rs2, ex_alt, ex_imm} !== {4'd8, 5'd3, 5'd1, 5'd2, 1'b1, 32'h0}) begin
            failures++; $display("FAIL sub got op=%0d rd=%0d rs1=%0d rs2=%0d alt=%b imm=%h exp op=8 rd=3 rs1=1 rs2=2 alt=1 imm=0",
                                 ex_op, ex_rd, ex_rs1, ex_rs2, ex_alt, ex_imm);
        end
        offer(32'h0020A423, 32'h110);
        tick;
        checks++;
        if ({ex_op, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_imm} !== {4'd6, 5'd0, 5'd1, 5'd2, 3'd2, 32'h8}) begin
            failures++; $display("FAIL sw got op=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h exp op=6 rd=0 rs1=1 rs2=2 f3=2 imm=8",
                                 ex_op, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_imm);
        end
        offer(32'hFF9FF0EF, 32'h114);
        tick;
        checks++;
        if ({ex_op, ex_rd, ex_rs1, ex_rs2, ex_imm} !== {4'd2, 5'd1, 5'd0, 5'd0, 32'hFFFFFFF8}) begin
            failures++; $display("FAIL jal got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h exp op=2 rd=1 rs1=0 rs2=0 imm=fffffff8",
                                 ex_op, ex_rd, ex_rs1, ex_rs2, ex_imm);
        end
        offer(32'h40335293, 32'h118);
        tick;
        checks++;
        if ({ex_op, ex_rd, ex_rs1, ex_funct3, ex_alt, ex_imm} !== {4'd7, 5'd5, 5'd6, 3'd5, 1'b1, 32'h403}) begin
            failures++; $display("FAIL srai got op=%0d rd=%0d rs1=%0d f3=%0d alt=%b imm=%h exp op=7 rd=5 rs1=6 f3=5 alt=1 imm=403",
                                 ex_op, ex_rd, ex_rs1, ex_funct3, ex_alt, ex_imm);
        end
        offer(32'h00000000, 32'h11C);
        tick;
        checks++;
        if ({ex_valid, ex_op, ex_illegal, ex_imm} !== {1'b1, 4'd15, 1'b1, 32'h0}) begin
            failures++; $display("FAIL illegal_zero got v=%b op=%0d ill=%b imm=%h exp v=1 op=15 ill=1 imm=0", ex_valid, ex_op, ex_illegal, ex_imm);
        end
        offer(32'hFFFFFFFC, 32'h120);
        tick;
        checks++;
        if ({ex_op, ex_illegal, ex_rd, ex_rs1, ex_rs2, ex_imm} !== {4'd15, 1'b1, 15'd0, 32'h0}) begin
            failures++; $display("FAIL illegal_low_bits got op=%0d ill=%b rd=%0d rs1=%0d rs2=%0d imm=%h exp op=15 ill=1 fields=0",
                                 ex_op, ex_illegal, ex_rd, ex_rs1, ex_rs2, ex_imm);
        end
        inst_valid = 1'b0;
        tick;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++; $display("FAIL decode_drain got=%b exp=0", ex_valid);
        end
    endtask

    task automatic test_back_to_back;
        ex_ready = 1'b0;
        offer(32'h00500093, 32'h200);
        tick;
        checks++;
        if ({ex_valid, ex_pc, id_ready} !== {1'b1, 32'h200, 1'b1}) begin
            failures++; $display("FAIL bp_a_main got v=%b pc=%h rdy=%b exp v=1 pc=200 rdy=1", ex_valid, ex_pc, id_ready);
        end
        offer(32'h123452B7, 32'h204);
        tick;
        checks++;
        if ({ex_pc, id_ready} !== {32'h200, 1'b0}) begin
            failures++; $display("FAIL bp_b_skid got pc=%h rdy=%b exp pc=200 rdy=0", ex_pc, id_ready);
        end
        offer(32'h402081B3, 32'h208);
        tick;
        checks++;
        if ({ex_valid, ex_pc, ex_op, id_ready} !== {1'b1, 32'h200, 4'd7, 1'b0}) begin
            failures++; $display("FAIL bp_hold got v=%b pc=%h op=%0d rdy=%b exp v=1 pc=200 op=7 rdy=0", ex_valid, ex_pc, ex_op, id_ready);
        end
        ex_ready = 1'b1;
        tick;
        checks++;
        if ({ex_valid, ex_pc, ex_op, id_ready} !== {1'b1, 32'h204, 4'd0, 1'b1}) begin
            failures++; $display("FAIL bp_b_out got v=%b pc=%h op=%0d rdy=%b exp v=1 pc=204 op=0 rdy=1", ex_valid, ex_pc, ex_op, id_ready);
        end
        tick;
        checks++;
        if ({ex_valid, ex_pc, ex_op} !== {1'b1, 32'h208, 4'd8}) begin
            failures++; $display("FAIL bp_c_out got v=%b pc=%h op=%0d exp v=1 pc=208 op=8", ex_valid, ex_pc, ex_op);
        end
        inst_valid = 1'b0;
        tick;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++; $display("FAIL bp_no_dup got=%b exp=0", ex_valid);
        end
    endtask

    task automatic test_flush;
        ex_ready = 1'b0;
        offer(32'h00500093, 32'h300);
        tick;
        offer(32'h123452B7, 32'h304);
        tick;
        checks++;
        if ({ex_valid, id_ready} !== 2'b10) begin
            failures++; $display("FAIL flush_fill got v_rdy=%b exp=10", {ex_valid, id_ready});
        end
        offer(32'h402081B3, 32'h308);
        wb_pc       = 32'h400;
        wb_pc_valid = 1'b1;
        tick;
        checks++;
        if ({ex_valid, id_ready} !== 2'b01) begin
            failures++; $display("FAIL flush_full got v_rdy=%b exp=01", {ex_valid, id_ready});
        end
        wb_pc_valid = 1'b0;
        inst_valid  = 1'b0;
        ex_ready    = 1'b1;
        tick;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++; $display("FAIL flush_no_ghost got=%b pc=%h exp=0", ex_valid, ex_pc);
        end
        offer(32'h0020A423, 32'h30C);
        wb_pc_valid = 1'b1;
        tick;
        checks++;
        if ({ex_valid, id_ready} !== 2'b01) begin
            failures++; $display("FAIL flush_accept got v_rdy=%b exp=01", {ex_valid, id_ready});
        end
        wb_pc_valid = 1'b0;
        offer(32'h00500093, 32'h310);
        tick;
        checks++;
        if ({ex_valid, ex_pc} !== {1'b1, 32'h310}) begin
            failures++; $display("FAIL flush_recover got v=%b pc=%h exp v=1 pc=310", ex_valid, ex_pc);
        end
        inst_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        ex_ready = 1'b0;
        offer(32'h00500093, 32'h500);
        tick;
        offer(32'h123452B7, 32'h504);
        tick;
        checks++;
        if ({ex_valid, id_ready} !== 2'b10) begin
            failures++; $display("FAIL rstmid_fill got v_rdy=%b exp=10", {ex_valid, id_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ex_valid, id_ready, ex_pc} !== {2'b00, 32'h0}) begin
            failures++; $display("FAIL rstmid_async got v=%b rdy=%b pc=%h exp v=0 rdy=0 pc=0", ex_valid, id_ready, ex_pc);
        end
        #2;
        rst        = 1'b1;
        inst_valid = 1'b0;
        ex_ready   = 1'b1;
        tick;
        checks++;
        if ({ex_valid, id_ready} !== 2'b01) begin
            failures++; $display("FAIL rstmid_release got v_rdy=%b exp=01", {ex_valid, id_ready});
        end
        tick;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_discard got v=%b pc=%h exp=0", ex_valid, ex_pc);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_decode;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
